// File: rtl/seg7_scan.sv
// rtl/seg7_scan.sv - 4-digit common-anode seven-segment scanner for the stopwatch (optional blink: SEG7_BLINK_EN)
module seg7_scan #(
    parameter int DIV          = 100000,
    parameter int BLANK        = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic [2:0] time_sec_h,
    input  logic [3:0] time_sec_l,
    input  logic [3:0] time_msec_h,
    input  logic [3:0] time_msec_l,
    input  logic       time_out,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX     = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_C  = PW'(BLANK);
    localparam bit            BLANK_EN = (BLANK > 0);

    localparam logic [6:0] SEG_OFF  = 7'b1111111;
    localparam logic [6:0] SEG_DASH = 7'b0111111;

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [14:0]   snap_q, snap_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;

    logic          tick;
    logic          frame_wrap;
    logic          in_blank;
    logic          blink_off;
    logic [3:0]    digit;
    logic [6:0]    seg_dec;

    assign tick       = (pcnt_q == PMAX);
    assign frame_wrap = tick && (idx_q == 2'd3);
    assign in_blank   = BLANK_EN && (pcnt_q < BLANK_C);

    // Prescaler, slot index and per-frame snapshot next-state
    always_comb begin
        pcnt_d = pcnt_q + 1'b1;
        idx_d  = idx_q;
        snap_d = snap_q;
        if (tick) begin
            pcnt_d = '0;
            idx_d  = idx_q + 2'd1;
        end
        if (frame_wrap) begin
            snap_d = {time_sec_h, time_sec_l, time_msec_h, time_msec_l};
        end
    end

    // Pick the BCD digit for the current slot out of the frozen snapshot
    always_comb begin
        digit = 4'd0;
        case (idx_q)
            2'd0: digit = snap_q[3:0];
            2'd1: digit = snap_q[7:4];
            2'd2: digit = snap_q[11:8];
            2'd3: digit = {1'b0, snap_q[14:12]};
            default: digit = 4'd0;
        endcase
    end

    // BCD to active-low {g,f,e,d,c,b,a}; non-BCD codes show a dash
    always_comb begin
        seg_dec = SEG_DASH;
        case (digit)
            4'd0: seg_dec = 7'b1000000;
            4'd1: seg_dec = 7'b1111001;
            4'd2: seg_dec = 7'b0100100;
            4'd3: seg_dec = 7'b0110000;
            4'd4: seg_dec = 7'b0011001;
            4'd5: seg_dec = 7'b0010010;
            4'd6: seg_dec = 7'b0000010;
            4'd7: seg_dec = 7'b1111000;
            4'd8: seg_dec = 7'b0000000;
            4'd9: seg_dec = 7'b0010000;
            default: seg_dec = SEG_DASH;
        endcase
    end

`ifdef SEG7_BLINK_EN
    localparam int            FW   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FW-1:0] FMAX = FW'(BLINK_FRAMES - 1);

    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;

    // Frame counter and blink phase; idle time_out parks the phase visible
    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (!time_out) begin
            fcnt_d  = '0;
            phase_d = 1'b1;
        end else if (frame_wrap) begin
            if (fcnt_q == FMAX) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Blink state registers
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q  <= '0;
            phase_q <= 1'b1;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blink_off = time_out & ~phase_q;
`else
    localparam int UNUSED_BLINK_FRAMES = BLINK_FRAMES;
    logic unused_time_out;
    assign unused_time_out = time_out;
    assign blink_off       = 1'b0;
`endif

    // Output next-state: blank window first, then anode/segment/dp for the slot
    always_comb begin
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_dec;
        dp_d  = (idx_q != 2'd2);
        if ((idx_q == 2'd3) && (snap_q[14:12] == 3'd0)) begin
            seg_d = SEG_OFF;
        end
        if (in_blank) begin
            an_d  = 4'b1111;
            seg_d = SEG_OFF;
            dp_d  = 1'b1;
        end
        if (blink_off) begin
            an_d = 4'b1111;
        end
    end

    // All state, including the registered display outputs
    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            idx_q  <= 2'd0;
            snap_q <= '0;
            an_q   <= 4'b1111;
            seg_q  <= SEG_OFF;
            dp_q   <= 1'b1;
        end else begin
            pcnt_q <= pcnt_d;
            idx_q  <= idx_d;
            snap_q <= snap_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            dp_q   <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan.sv
// tb/tb_seg7_scan.sv - directed self-checking bench for seg7_scan (DIV=4, BLANK=1)
module tb_seg7_scan;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sec_h;
    logic [3:0] sec_l;
    logic [3:0] msec_h;
    logic [3:0] msec_l;
    logic       tout;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int blanks = 0;

    seg7_scan #(.DIV(4), .BLANK(1), .BLINK_FRAMES(2)) dut (
        .clk_100mhz (clk),
        .rst_n      (rst_n),
        .time_sec_h (sec_h),
        .time_sec_l (sec_l),
        .time_msec_h(msec_h),
        .time_msec_l(msec_l),
        .time_out   (tout),
        .an         (an),
        .seg        (seg),
        .dp         (dp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after rising edge number 'target' since reset release
    task automatic adv(input int target);
        while (edge_n < target) begin
            @(posedge clk);
            edge_n++;
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        tout   = 1'b0;
        sec_h  = 3'd0;
        sec_l  = 4'd0;
        msec_h = 4'd0;
        msec_l = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an",  7'(an),  7'b0001111);
        chk("rst_seg", seg,     7'b1111111);
        chk("rst_dp",  7'(dp),  7'd1);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;

        // frame 0: all-zero snapshot
        adv(1);
        chk("f0_s0_blank_an", 7'(an), 7'b0001111);
        adv(2);
        chk("f0_s0_an",  7'(an), 7'b0001110);
        chk("f0_s0_seg", seg,    7'b1000000);
        chk("f0_s0_dp",  7'(dp), 7'd1);
        adv(14);
        chk("f0_s3_an",  7'(an), 7'b0000111);
        chk("f0_s3_seg", seg,    7'b1111111);

        // frame 1: 59.98
        sec_h = 3'd5; sec_l = 4'd9; msec_h = 4'd9; msec_l = 4'd8;
        adv(17);
        chk("f1_s0_blank_an",  7'(an), 7'b0001111);
        chk("f1_s0_blank_seg", seg,    7'b1111111);
        adv(18);
        chk("f1_s0_an",  7'(an), 7'b0001110);
        chk("f1_s0_seg", seg,    7'b0000000);
        adv(22);
        chk("f1_s1_an",  7'(an), 7'b0001101);
        chk("f1_s1_seg", seg,    7'b0010000);
        adv(26);
        chk("f1_s2_an",  7'(an), 7'b0001011);
        chk("f1_s2_seg", seg,    7'b0010000);
        chk("f1_s2_dp",  7'(dp), 7'd0);
        adv(30);
        chk("f1_s3_an",  7'(an), 7'b0000111);
        chk("f1_s3_seg", seg,    7'b0010010);
        chk("f1_s3_dp",  7'(dp), 7'd1);

        // frame 2: msec_l=3, count blank cycles over the whole frame
        msec_l = 4'd3;
        for (int e = 33; e <= 48; e++) begin
            adv(e);
            if (an == 4'b1111) blanks++;
            if (e == 34) chk("f2_s0_seg", seg, 7'b0110000);
        end
        chk("f2_blank_count", 7'(blanks), 7'd4);

        // frame 3: change inputs while idx=1; current frame must keep old snapshot
        adv(54);
        msec_l = 4'd7;
        sec_h  = 3'd2;
        adv(62);
        chk("f3_s3_old_seg", seg, 7'b0010010);
        adv(66);
        chk("f4_s0_new_seg", seg, 7'b1111000);
        adv(78);
        chk("f4_s3_new_seg", seg, 7'b0100100);

        // non-BCD value shows a dash
        msec_l = 4'd12;
        adv(82);
        chk("f5_s0_dash_an",  7'(an), 7'b0001110);
        chk("f5_s0_dash_seg", seg,    7'b0111111);

        // asynchronous reset in the middle of slot 2
        adv(90);
        chk("f5_s2_an", 7'(an), 7'b0001011);
        chk("f5_s2_dp", 7'(dp), 7'd0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_an",  7'(an), 7'b0001111);
        chk("async_rst_seg", seg,    7'b1111111);
        chk("async_rst_dp",  7'(dp), 7'd1);
        @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        tout   = 1'b1;

        // scanning restarts at slot 0 with zero snapshot and pcnt=0
        adv(1);
        chk("rs_blank_an", 7'(an), 7'b0001111);
        adv(2);
        chk("rs_s0_an",  7'(an), 7'b0001110);
        chk("rs_s0_seg", seg,    7'b1000000);
        adv(4);
        chk("rs_s0_last_an", 7'(an), 7'b0001110);
        adv(5);
        chk("rs_s1_blank_an", 7'(an), 7'b0001111);
        adv(6);
        chk("rs_s1_an", 7'(an), 7'b0001101);

`ifdef SEG7_BLINK_EN
        // two visible frames, then two dark frames, then visible again
        adv(34);
        chk("blink_off_f2_an", 7'(an), 7'b0001111);
        adv(38);
        chk("blink_off_f2s1_an", 7'(an), 7'b0001111);
        adv(66);
        chk("blink_on_f4_an", 7'(an), 7'b0001110);
        adv(98);
        chk("blink_off_f6_an", 7'(an), 7'b0001111);
        tout = 1'b0;
        adv(99);
        chk("blink_drop_an", 7'(an), 7'b0001110);
`else
        // time_out has no effect on the anodes
        adv(34);
        chk("tout_f2_s0_an", 7'(an), 7'b0001110);
        adv(38);
        chk("tout_f2_s1_an", 7'(an), 7'b0001101);
        adv(98);
        chk("tout_f6_s0_an", 7'(an), 7'b0001110);
        tout = 1'b0;
        adv(99);
        chk("tout_drop_an", 7'(an), 7'b0001110);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
